// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt vector dispatcher.
package irq_pkg;

  localparam int unsigned IRQ_W  = 4;
  localparam int unsigned MASK_W = 2;
  localparam int unsigned LVL_W  = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned PC_W   = 16;

  localparam int unsigned        IRQ_TIMEOUT_DEFAULT = 16;
  localparam logic [ADDR_W-1:0]  IRQ_VECTOR_BASE     = 24'h000000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACK   = 3'd1,
    ST_RD_LO = 3'd2,
    ST_RD_HI = 3'd3,
    ST_DONE  = 3'd4
  } irq_state_e;

  // Vector table byte address; the high byte sits one above and wraps at 24 bits.
  function automatic logic [ADDR_W-1:0] vec_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [DATA_W-1:0] off,
                                                 input logic              hi);
    return base + ADDR_W'(off) + ADDR_W'(hi);
  endfunction

endpackage

// File: rtl/irq_dispatch_if.sv
// CPU, interrupt controller and memory bus signals seen by the dispatcher.
interface irq_dispatch_if;
  import irq_pkg::*;

  logic [IRQ_W-1:0]  cpu_irq;
  logic [MASK_W-1:0] cpu_mask;
  logic              instr_boundary;
  logic [DATA_W-1:0] bus_data_in;
  logic              mem_ready;
  logic              cpu_iack;
  logic              bus_read;
  logic [ADDR_W-1:0] bus_address_out;
  logic              cpu_stall;
  logic [PC_W-1:0]   vector_pc;
  logic              vector_valid;
  logic [LVL_W-1:0]  taken_level;
  logic              bus_error;

  modport master (
    output cpu_irq, cpu_mask, instr_boundary, bus_data_in, mem_ready,
    input  cpu_iack, bus_read, bus_address_out, cpu_stall,
    input  vector_pc, vector_valid, taken_level, bus_error
  );

  modport slave (
    input  cpu_irq, cpu_mask, instr_boundary, bus_data_in, mem_ready,
    output cpu_iack, bus_read, bus_address_out, cpu_stall,
    output vector_pc, vector_valid, taken_level, bus_error
  );

endinterface

// File: rtl/irq_level_enc.sv
// Request level encoder and mask compare. IRQ_DISPATCH_NMI_EN turns cpu_irq[3]
// into a non-maskable request reported as level 3; otherwise that bit is ignored.
module irq_level_enc
  import irq_pkg::*;
(
  input  logic [IRQ_W-1:0]  i_irq,
  input  logic [MASK_W-1:0] i_mask,
  input  logic              i_boundary,
  output logic [LVL_W-1:0]  o_level_c,
  output logic              o_accept_c
);

  logic [LVL_W-1:0] w_maskable_level;

  // Highest set bit among the maskable requests wins.
  always_comb begin
    w_maskable_level = '0;
    if (i_irq[2])      w_maskable_level = LVL_W'(3);
    else if (i_irq[1]) w_maskable_level = LVL_W'(2);
    else if (i_irq[0]) w_maskable_level = LVL_W'(1);
  end

`ifdef IRQ_DISPATCH_NMI_EN
  always_comb begin
    o_level_c  = w_maskable_level;
    o_accept_c = i_boundary && (w_maskable_level > i_mask);
    if (i_irq[3]) begin
      o_level_c  = LVL_W'(3);
      o_accept_c = i_boundary;
    end
  end
`else
  logic w_unused_nmi;
  assign w_unused_nmi = i_irq[3];

  always_comb begin
    o_level_c  = w_maskable_level;
    o_accept_c = i_boundary && (w_maskable_level > i_mask);
  end
`endif

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: acknowledge, fetch the 16-bit handler vector, report it.
// Optional NMI handling via IRQ_DISPATCH_NMI_EN (see irq_level_enc).
module irq_dispatch
  import irq_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = IRQ_TIMEOUT_DEFAULT,
  parameter logic [ADDR_W-1:0] VECTOR_BASE    = IRQ_VECTOR_BASE
) (
  input logic           clk,
  input logic           reset,
  input logic           clk_ce,
  irq_dispatch_if.slave bus
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  irq_state_e        r_state,  w_state;
  logic              r_iack,   w_iack;
  logic              r_read,   w_read;
  logic [ADDR_W-1:0] r_addr,   w_addr;
  logic              r_stall,  w_stall;
  logic [PC_W-1:0]   r_pc,     w_pc;
  logic              r_valid,  w_valid;
  logic [LVL_W-1:0]  r_level,  w_level;
  logic              r_err,    w_err;
  logic [DATA_W-1:0] r_offset, w_offset;
  logic [CNT_W-1:0]  r_cnt,    w_cnt;

  logic [LVL_W-1:0]  w_enc_level;
  logic              w_accept;

  irq_level_enc u_level_enc (
    .i_irq      (bus.cpu_irq),
    .i_mask     (bus.cpu_mask),
    .i_boundary (bus.instr_boundary),
    .o_level_c  (w_enc_level),
    .o_accept_c (w_accept)
  );

  // Next state and next registered outputs; pulses default low.
  always_comb begin
    w_state  = r_state;
    w_iack   = r_iack;
    w_read   = r_read;
    w_addr   = r_addr;
    w_stall  = r_stall;
    w_pc     = r_pc;
    w_level  = r_level;
    w_offset = r_offset;
    w_cnt    = r_cnt;
    w_valid  = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state = ST_ACK;
          w_level = w_enc_level;
          w_stall = 1'b1;
          w_iack  = 1'b1;
        end
      end
      ST_ACK: begin
        w_iack   = 1'b0;
        w_offset = bus.bus_data_in;
        w_read   = 1'b1;
        w_addr   = vec_addr(VECTOR_BASE, bus.bus_data_in, 1'b0);
        w_cnt    = '0;
        w_state  = ST_RD_LO;
      end
      ST_RD_LO, ST_RD_HI: begin
        if (bus.mem_ready) begin
          w_cnt = '0;
          if (r_state == ST_RD_LO) begin
            w_pc[7:0] = bus.bus_data_in;
            w_addr    = vec_addr(VECTOR_BASE, r_offset, 1'b1);
            w_state   = ST_RD_HI;
          end else begin
            w_pc[15:8] = bus.bus_data_in;
            w_read     = 1'b0;
            w_addr     = '0;
            w_stall    = 1'b0;
            w_valid    = 1'b1;
            w_state    = ST_DONE;
          end
        end else if (r_cnt == CNT_LAST) begin
          // Memory never answered: abandon the dispatch and release the CPU.
          w_cnt   = '0;
          w_read  = 1'b0;
          w_addr  = '0;
          w_stall = 1'b0;
          w_err   = 1'b1;
          w_state = ST_IDLE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
        w_iack  = 1'b0;
        w_read  = 1'b0;
        w_addr  = '0;
        w_stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk_ce) begin
      if (reset) begin
        r_state  <= ST_IDLE;
        r_iack   <= 1'b0;
        r_read   <= 1'b0;
        r_addr   <= '0;
        r_stall  <= 1'b0;
        r_pc     <= '0;
        r_valid  <= 1'b0;
        r_level  <= '0;
        r_err    <= 1'b0;
        r_offset <= '0;
        r_cnt    <= '0;
      end else begin
        r_state  <= w_state;
        r_iack   <= w_iack;
        r_read   <= w_read;
        r_addr   <= w_addr;
        r_stall  <= w_stall;
        r_pc     <= w_pc;
        r_valid  <= w_valid;
        r_level  <= w_level;
        r_err    <= w_err;
        r_offset <= w_offset;
        r_cnt    <= w_cnt;
      end
    end
  end

  assign bus.cpu_iack        = r_iack;
  assign bus.bus_read        = r_read;
  assign bus.bus_address_out = r_addr;
  assign bus.cpu_stall       = r_stall;
  assign bus.vector_pc       = r_pc;
  assign bus.vector_valid    = r_valid;
  assign bus.taken_level     = r_level;
  assign bus.bus_error       = r_err;

endmodule

// File: doc/irq_dispatch.md
IRQ_DISPATCH -- requirements
Module: irq_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max clk_ce cycles to wait for mem_ready per byte read.
REQ-002 SHALL have parameter VECTOR_BASE, default 24'h000000, base address added to the vector byte offset.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset, sampled only on clk_ce.
REQ-005 SHALL have port clk_ce, input, 1, clock enable; no state changes when low.
REQ-006 SHALL have port cpu_irq, input, 4, one-hot level request from the interrupt controller; bit n means level n+1.
REQ-007 SHALL have port cpu_mask, input, 2, the CPU interrupt priority mask (I bits).
REQ-008 SHALL have port instr_boundary, input, 1, high when the CPU may accept an interrupt.
REQ-009 SHALL have port bus_data_in, input, 8, read data (vector offset during iack, memory byte otherwise).
REQ-010 SHALL have port mem_ready, input, 1, memory read data valid this cycle.
REQ-011 SHALL have port cpu_iack, output, 1, interrupt acknowledge to the controller.
REQ-012 SHALL have port bus_read, output, 1, memory read request.
REQ-013 SHALL have port bus_address_out, output, 24, read address.
REQ-014 SHALL have port cpu_stall, output, 1, holds the CPU while a dispatch is in progress.
REQ-015 SHALL have port vector_pc, output, 16, fetched handler address.
REQ-016 SHALL have port vector_valid, output, 1, one-clk_ce-cycle pulse when vector_pc is valid.
REQ-017 SHALL have port taken_level, output, 2, level of the dispatched interrupt, valid with vector_valid.
REQ-018 SHALL have port bus_error, output, 1, one-cycle pulse on read timeout.

Function
REQ-019 SHALL encode the request level as the index+1 of the highest set cpu_irq bit, or 0 if none.
REQ-020 SHALL accept a request in IDLE only when level > cpu_mask and instr_boundary=1.
REQ-021 SHALL use states IDLE, ACK, RD_LO, RD_HI, DONE, advancing at most once per clk_ce cycle.
REQ-022 SHALL go IDLE->ACK on accept, latching level into taken_level and asserting cpu_stall from that cycle.
REQ-023 SHALL assert cpu_iack only in ACK for exactly one clk_ce cycle, latch bus_data_in as offset, and go to RD_LO.
REQ-024 SHALL in RD_LO drive bus_read=1 with bus_address_out=VECTOR_BASE+offset, and on mem_ready latch vector_pc[7:0] and go to RD_HI.
REQ-025 SHALL in RD_HI drive bus_read=1 with bus_address_out=VECTOR_BASE+offset+1 (24-bit wrap), and on mem_ready latch vector_pc[15:8] and go to DONE.
REQ-026 SHALL in DONE pulse vector_valid for one cycle, deassert cpu_stall, and return to IDLE.
REQ-027 SHALL ignore cpu_irq changes after ACK; a request dropped mid-sequence still completes with the latched offset.
REQ-028 SHALL count clk_ce cycles in RD_LO/RD_HI, reset the count on each state entry, and on reaching TIMEOUT_CYCLES without mem_ready pulse bus_error, drop cpu_stall, and return to IDLE with no vector_valid.
REQ-029 SHALL not re-accept in the cycle DONE->IDLE; the earliest new accept is the next clk_ce cycle.
REQ-030 SHALL drive bus_address_out=0 and bus_read=0 outside RD_LO/RD_HI.

Reset
REQ-031 SHALL on reset force IDLE, clearing cpu_iack, bus_read, cpu_stall, vector_valid, bus_error, vector_pc, taken_level, and bus_address_out to 0, including mid-sequence.

Configuration
REQ-032 SHALL with IRQ_DISPATCH_NMI_EN defined treat cpu_irq[3] as NMI: accept it regardless of cpu_mask, report taken_level=3, and give it priority over all other bits.
REQ-033 SHALL without IRQ_DISPATCH_NMI_EN ignore cpu_irq[3] entirely.

Structure
REQ-034 SHALL place the state enum, default TIMEOUT_CYCLES, and VECTOR_BASE constants in shared package irq_pkg.
REQ-035 SHALL implement the level encode/mask compare in sub-module irq_level_enc; the FSM stays in irq_dispatch.

Verification
REQ-036 SHALL test: cpu_irq=4'b0010, mask=0, boundary=1, iack data 8'h0C, memory 0x0C=8'h34, 0x0D=8'h12 -> vector_pc=16'h1234, taken_level=2, single vector_valid.
REQ-037 SHALL test: cpu_irq=4'b0001, mask=1 -> no cpu_iack, cpu_stall stays 0.
REQ-038 SHALL test: mem_ready held 0 in RD_LO for 16 clk_ce cycles -> bus_error pulse, IDLE, no vector_valid.
REQ-039 SHALL test: reset asserted in RD_HI -> all outputs 0 on the next clk_ce cycle and state IDLE.
REQ-040 SHALL test: NMI_EN defined, cpu_irq=4'b1001, mask=3 -> accept with taken_level=3; undefined -> no accept.
